// File: rtl/ntt_sdf_ctrl.sv
// Sequencer for a chain of SDF NTT/INTT stages: feeds N samples into stage 0,
// collects the last stage's output strobes into write addresses, and watchdogs the drain.
module ntt_sdf_ctrl #(
    parameter int unsigned LOGN       = 8,
    parameter int unsigned DELAY_BRAM = 1,
    parameter int unsigned PIPE_LAT   = 512,
    parameter int unsigned BITREV_OUT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  logic            intt_mode,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            in_rd_en,
    output logic [LOGN-1:0] in_rd_addr,
    output logic            pipe_start,
    output logic            pipe_intt,
    input  logic            pipe_finish,
    output logic            out_wr_en,
    output logic [LOGN-1:0] out_wr_addr
);
    localparam int unsigned WD_LIMIT = PIPE_LAT + (1 << LOGN);
    localparam int unsigned WDW      = $clog2(WD_LIMIT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [LOGN-1:0] rd_cnt, wr_cnt, wr_rev;
    logic [WDW-1:0]  wd_cnt;
    logic            accept, active, last_wr, timeout;

    assign accept  = (state == S_IDLE) && go;
    assign active  = (state == S_FEED) || (state == S_DRAIN);
    assign last_wr = pipe_finish && (wr_cnt == '1);
    // The Nth finish takes priority over a watchdog expiry in the same cycle.
    assign timeout = (state == S_DRAIN) && !pipe_finish && (wd_cnt == WDW'(WD_LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) state_nxt = S_FEED;
            end
            S_FEED: begin
                busy      = 1'b1;
                in_rd_en  = 1'b1;
                out_wr_en = pipe_finish;
                if (last_wr)            state_nxt = S_DONE;
                else if (rd_cnt == '1)  state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy      = 1'b1;
                out_wr_en = pipe_finish;
                if (last_wr)      state_nxt = S_DONE;
                else if (timeout) state_nxt = S_IDLE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            wd_cnt    <= '0;
            pipe_intt <= 1'b0;
            err       <= 1'b0;
        end else if (accept) begin
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            wd_cnt    <= '0;
            pipe_intt <= intt_mode;
            err       <= 1'b0;
        end else begin
            if (state == S_FEED) rd_cnt <= rd_cnt + 1'b1;
            if (out_wr_en)       wr_cnt <= wr_cnt + 1'b1;
            if (active && pipe_finish)
                wd_cnt <= '0;
            else if ((state == S_DRAIN) && (wd_cnt != '1))
                wd_cnt <= wd_cnt + 1'b1;
            if (timeout) err <= 1'b1;
        end
    end

    generate
        if (DELAY_BRAM == 0) begin : g_nodly
            assign pipe_start = in_rd_en;
        end else begin : g_dly
            // Matches the input-memory read latency so pipe_start lines up with read data.
            logic [DELAY_BRAM-1:0] start_sr;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    start_sr <= '0;
                end else begin
                    start_sr[0] <= in_rd_en;
                    for (int unsigned i = 1; i < DELAY_BRAM; i++)
                        start_sr[i] <= start_sr[i-1];
                end
            end
            assign pipe_start = start_sr[DELAY_BRAM-1];
        end
    endgenerate

    always_comb begin
        wr_rev = '0;
        for (int unsigned i = 0; i < LOGN; i++)
            wr_rev[i] = wr_cnt[LOGN-1-i];
    end

    assign in_rd_addr  = rd_cnt;
    assign out_wr_addr = (BITREV_OUT != 0) ? wr_rev : wr_cnt;

endmodule

// File: tb/tb_ntt_sdf_ctrl.sv
// Bench for ntt_sdf_ctrl: three LOGN=3 instances (natural, bit-reversed, zero-latency read)
// with delay-line models of the stage pipeline and a write-address scoreboard.
module tb_ntt_sdf_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       go_a = 0, intt_a = 0, fin_a;
    logic       busy_a, done_a, err_a, rd_en_a, start_a, pintt_a, wr_en_a;
    logic [2:0] rd_addr_a, wr_addr_a;
    logic       go_b = 0, intt_b = 0, fin_b;
    logic       busy_b, done_b, err_b, rd_en_b, start_b, pintt_b, wr_en_b;
    logic [2:0] rd_addr_b, wr_addr_b;
    logic       go_c = 0, intt_c = 0, fin_c;
    logic       busy_c, done_c, err_c, rd_en_c, start_c, pintt_c, wr_en_c;
    logic [2:0] rd_addr_c, wr_addr_c;

    ntt_sdf_ctrl #(.LOGN(3), .DELAY_BRAM(1), .PIPE_LAT(16), .BITREV_OUT(0)) dut_a (
        .clk(clk), .rst(rst), .go(go_a), .intt_mode(intt_a), .busy(busy_a), .done(done_a),
        .err(err_a), .in_rd_en(rd_en_a), .in_rd_addr(rd_addr_a), .pipe_start(start_a),
        .pipe_intt(pintt_a), .pipe_finish(fin_a), .out_wr_en(wr_en_a), .out_wr_addr(wr_addr_a));
    ntt_sdf_ctrl #(.LOGN(3), .DELAY_BRAM(1), .PIPE_LAT(16), .BITREV_OUT(1)) dut_b (
        .clk(clk), .rst(rst), .go(go_b), .intt_mode(intt_b), .busy(busy_b), .done(done_b),
        .err(err_b), .in_rd_en(rd_en_b), .in_rd_addr(rd_addr_b), .pipe_start(start_b),
        .pipe_intt(pintt_b), .pipe_finish(fin_b), .out_wr_en(wr_en_b), .out_wr_addr(wr_addr_b));
    ntt_sdf_ctrl #(.LOGN(3), .DELAY_BRAM(0), .PIPE_LAT(16), .BITREV_OUT(0)) dut_c (
        .clk(clk), .rst(rst), .go(go_c), .intt_mode(intt_c), .busy(busy_c), .done(done_c),
        .err(err_c), .in_rd_en(rd_en_c), .in_rd_addr(rd_addr_c), .pipe_start(start_c),
        .pipe_intt(pintt_c), .pipe_finish(fin_c), .out_wr_en(wr_en_c), .out_wr_addr(wr_addr_c));

    // Stage-chain models: 20-cycle pipeline for a/b, 1-cycle pipeline for c.
    logic [19:0] line_a = '0, line_b = '0;
    logic        line_c = 1'b0;
    logic        fin_en_a = 1'b1, stray_a = 1'b0;
    always @(posedge clk) begin
        line_a <= {line_a[18:0], start_a};
        line_b <= {line_b[18:0], start_b};
        line_c <= start_c;
    end
    assign fin_a = (fin_en_a & line_a[19]) | stray_a;
    assign fin_b = line_b[19];
    assign fin_c = line_c;

    typedef struct { logic [2:0] addr; int cyc; } wr_t;
    wr_t sb[$];
    int tests = 0;
    int fails = 0;
    logic [2:0] rev_tab [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy_a, done_a, err_a, rd_en_a, start_a, pintt_a, wr_en_a, rd_addr_a, wr_addr_a} !== 13'd0) begin
            fails++;
            $display("FAIL reset_a: got %b want 0", {busy_a, done_a, err_a, rd_en_a, start_a, pintt_a, wr_en_a, rd_addr_a, wr_addr_a});
        end
        tests++;
        if ({busy_b, done_b, err_b, rd_en_b, start_b, pintt_b, wr_en_b, busy_c, done_c, rd_en_c, start_c, wr_en_c} !== 12'd0) begin
            fails++;
            $display("FAIL reset_bc: got %b want 0", {busy_b, done_b, err_b, rd_en_b, start_b, pintt_b, wr_en_b, busy_c, done_c, rd_en_c, start_c, wr_en_c});
        end
        rst = 1'b0;
    endtask

    task automatic test_main(input bit intt);
        int writes = 0, dones = 0;
        bit e;
        wr_t x;
        @(negedge clk);
        go_a = 1'b1; intt_a = intt;
        for (int i = 0; i < 8; i++) sb.push_back('{3'(i), 22 + i});
        @(negedge clk);
        go_a = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            e = (c >= 1 && c <= 8);
            tests++;
            if (rd_en_a !== e) begin fails++; $display("FAIL main.rd_en c%0d: got %b want %b", c, rd_en_a, e); end
            if (e) begin
                tests++;
                if (rd_addr_a !== 3'(c - 1)) begin fails++; $display("FAIL main.rd_addr c%0d: got %0d want %0d", c, rd_addr_a, c - 1); end
            end
            e = (c >= 2 && c <= 9);
            tests++;
            if (start_a !== e) begin fails++; $display("FAIL main.start c%0d: got %b want %b", c, start_a, e); end
            e = (c <= 29);
            tests++;
            if (busy_a !== e) begin fails++; $display("FAIL main.busy c%0d: got %b want %b", c, busy_a, e); end
            e = (c == 30);
            tests++;
            if (done_a !== e) begin fails++; $display("FAIL main.done c%0d: got %b want %b", c, done_a, e); end
            tests++;
            if (err_a !== 1'b0) begin fails++; $display("FAIL main.err c%0d: got %b want 0", c, err_a); end
            tests++;
            if (pintt_a !== intt) begin fails++; $display("FAIL main.intt c%0d: got %b want %b", c, pintt_a, intt); end
            if (done_a === 1'b1) dones++;
            if (wr_en_a === 1'b1) begin
                writes++;
                tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL main.wr_extra c%0d: got addr %0d want no write", c, wr_addr_a);
                end else begin
                    x = sb.pop_front();
                    if (wr_addr_a !== x.addr || c != x.cyc) begin
                        fails++; $display("FAIL main.wr c%0d: got addr %0d want addr %0d at c%0d", c, wr_addr_a, x.addr, x.cyc);
                    end
                end
            end
            @(negedge clk);
        end
        tests++;
        if (writes != 8 || dones != 1) begin fails++; $display("FAIL main.count: got %0d writes %0d done want 8 1", writes, dones); end
        sb.delete();
    endtask

    task automatic test_bitrev;
        int writes = 0;
        wr_t x;
        @(negedge clk);
        go_b = 1'b1;
        for (int i = 0; i < 8; i++) sb.push_back('{rev_tab[i], 22 + i});
        @(negedge clk);
        go_b = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            tests++;
            if (done_b !== (c == 30)) begin fails++; $display("FAIL bitrev.done c%0d: got %b want %b", c, done_b, c == 30); end
            if (wr_en_b === 1'b1) begin
                writes++;
                tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL bitrev.wr_extra c%0d: got addr %0d want no write", c, wr_addr_b);
                end else begin
                    x = sb.pop_front();
                    if (wr_addr_b !== x.addr || c != x.cyc) begin
                        fails++; $display("FAIL bitrev.wr c%0d: got addr %0d want addr %0d at c%0d", c, wr_addr_b, x.addr, x.cyc);
                    end
                end
            end
            @(negedge clk);
        end
        tests++;
        if (writes != 8) begin fails++; $display("FAIL bitrev.count: got %0d want 8", writes); end
        sb.delete();
    endtask

    task automatic test_back_to_back;
        int writes = 0, dones = 0;
        wr_t x;
        @(negedge clk);
        go_a = 1'b1; intt_a = 1'b1;
        for (int i = 0; i < 8; i++) sb.push_back('{3'(i), 22 + i});
        @(negedge clk);
        go_a = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            go_a   = (c == 5);
            intt_a = (c != 5);
            tests++;
            if (pintt_a !== 1'b1) begin fails++; $display("FAIL b2b.intt c%0d: got %b want 1", c, pintt_a); end
            tests++;
            if (busy_a !== (c <= 29)) begin fails++; $display("FAIL b2b.busy c%0d: got %b want %b", c, busy_a, c <= 29); end
            if (done_a === 1'b1) dones++;
            if (wr_en_a === 1'b1) begin
                writes++;
                tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL b2b.wr_extra c%0d: got addr %0d want no write", c, wr_addr_a);
                end else begin
                    x = sb.pop_front();
                    if (wr_addr_a !== x.addr || c != x.cyc) begin
                        fails++; $display("FAIL b2b.wr c%0d: got addr %0d want addr %0d at c%0d", c, wr_addr_a, x.addr, x.cyc);
                    end
                end
            end
            @(negedge clk);
        end
        go_a = 1'b0; intt_a = 1'b0;
        tests++;
        if (writes != 8 || dones != 1) begin fails++; $display("FAIL b2b.count: got %0d writes %0d done want 8 1", writes, dones); end
        sb.delete();
    endtask

    task automatic test_watchdog;
        fin_en_a = 1'b0;
        @(negedge clk);
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tests++;
            if (busy_a !== (c <= 32)) begin fails++; $display("FAIL wd.busy c%0d: got %b want %b", c, busy_a, c <= 32); end
            tests++;
            if (err_a !== (c >= 33)) begin fails++; $display("FAIL wd.err c%0d: got %b want %b", c, err_a, c >= 33); end
            tests++;
            if (done_a !== 1'b0 || wr_en_a !== 1'b0) begin fails++; $display("FAIL wd.quiet c%0d: got done %b wr %b want 0 0", c, done_a, wr_en_a); end
            @(negedge clk);
        end
        fin_en_a = 1'b1;
        test_main(1'b0);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        go_a = 1'b1; intt_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0; intt_a = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if ({busy_a, done_a, err_a, rd_en_a, start_a, pintt_a, wr_en_a, rd_addr_a, wr_addr_a} !== 13'd0) begin
            fails++;
            $display("FAIL rst_mid.async: got %b want 0", {busy_a, done_a, err_a, rd_en_a, start_a, pintt_a, wr_en_a, rd_addr_a, wr_addr_a});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            stray_a = (c % 3 == 0);
            #1;
            tests++;
            if (wr_en_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
                fails++; $display("FAIL rst_mid.stray c%0d: got wr %b busy %b done %b want 0 0 0", c, wr_en_a, busy_a, done_a);
            end
            @(negedge clk);
        end
        stray_a = 1'b0;
        test_main(1'b1);
    endtask

    task automatic test_overlap;
        int writes = 0;
        wr_t x;
        @(negedge clk);
        go_c = 1'b1;
        for (int i = 0; i < 8; i++) sb.push_back('{3'(i), 2 + i});
        @(negedge clk);
        go_c = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            tests++;
            if (rd_en_c !== (c <= 8) || start_c !== (c <= 8)) begin
                fails++; $display("FAIL overlap.rd c%0d: got rd %b start %b want %b", c, rd_en_c, start_c, c <= 8);
            end
            tests++;
            if (busy_c !== (c <= 9) || done_c !== (c == 10)) begin
                fails++; $display("FAIL overlap.hs c%0d: got busy %b done %b want %b %b", c, busy_c, done_c, c <= 9, c == 10);
            end
            if (wr_en_c === 1'b1) begin
                writes++;
                tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL overlap.wr_extra c%0d: got addr %0d want no write", c, wr_addr_c);
                end else begin
                    x = sb.pop_front();
                    if (wr_addr_c !== x.addr || c != x.cyc) begin
                        fails++; $display("FAIL overlap.wr c%0d: got addr %0d want addr %0d at c%0d", c, wr_addr_c, x.addr, x.cyc);
                    end
                end
            end
            @(negedge clk);
        end
        tests++;
        if (writes != 8) begin fails++; $display("FAIL overlap.count: got %0d want 8", writes); end
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_main(1'b0);
        test_bitrev();
        test_back_to_back();
        test_watchdog();
        test_reset_mid();
        test_overlap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
